// File: rtl/fxb_pkg.sv
// fxb_pkg: shared table sizes, state encoding, default widths and error magnitude helper
package fxb_pkg;
  localparam int XLEN = 8;
  localparam int DLEN = 9;
  localparam int XW_D = 8;
  localparam int DW_D = 10;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic int sat_mag(input int v, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    return (v < 0) ? ((-v > lim) ? lim : -v) : v;
  endfunction
endpackage

// File: rtl/fxb_errmon.sv
// fxb_errmon: per-frame error magnitude check with saturating in-threshold run counter and conv flag
module fxb_errmon import fxb_pkg::*; #(
  parameter int DW = DW_D,
  parameter int THR = 4,
  parameter int CONV = 16
)(
  input  logic          clk,
  input  logic          r,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] e_in,
  output logic          conv
);
  localparam int CW = $clog2(CONV + 1);
  logic [CW-1:0] okcnt, ok_nx;
  logic [DW-2:0] mag;
  always_comb begin
    mag = (DW-1)'(sat_mag(int'($signed(e_in)), DW));
    ok_nx = (int'(mag) <= THR) ? ((int'(okcnt) == CONV) ? okcnt : okcnt + 1'b1) : '0;
  end
  always_ff @(posedge clk) begin
    if (!r || clr) begin
      okcnt <= '0;
      conv <= 1'b0;
    end else if (en) begin
      okcnt <= ok_nx;
      conv <= (int'(ok_nx) == CONV);
    end
  end
endmodule

// File: rtl/fxb_source.sv
// fxb_source: table-driven x/d stimulus sequencer for the DA filter with per-frame error capture
module fxb_source import fxb_pkg::*; #(
  parameter int XW = XW_D,
  parameter int DW = DW_D,
  parameter int FRAME = 8,
  parameter int NPASS = 50,
  parameter int THR = 4,
  parameter int CONV = 16
)(
  input  logic          clk,
  input  logic          r,
  input  logic          start,
  input  logic          we,
  input  logic          wsel,
  input  logic [3:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] e_in,
  output logic [XW-1:0] xn,
  output logic [DW-1:0] d,
  output logic          stb,
  output logic          busy,
  output logic          done,
  output logic          conv,
  output logic [5:0]    pass
);
  localparam int PW = (FRAME > 1) ? $clog2(FRAME) : 1;
  logic [1:0] state;
  logic [PW-1:0] phase;
  logic [2:0] i;
  logic [3:0] j;
  logic [XW-1:0] xtab [XLEN];
  logic [DW-1:0] dtab [DLEN];
  logic idle_ok, go, fend, last;
  always_comb begin
    idle_ok = (state != S_RUN);
    go = idle_ok && start;
    fend = (state == S_RUN) && (int'(phase) == FRAME - 1);
    last = fend && (i == 3'd7) && (int'(pass) == NPASS - 1);
  end
  assign busy = (state == S_RUN);
  always_ff @(posedge clk) begin
    if (!r) begin
      state <= S_IDLE;
      phase <= '0;
      i <= '0;
      j <= '0;
      pass <= '0;
      xn <= '0;
      d <= '0;
      stb <= 1'b0;
      done <= 1'b0;
      for (int k = 0; k < XLEN; k++) xtab[k] <= '0;
      for (int k = 0; k < DLEN; k++) dtab[k] <= '0;
    end else begin
      stb <= 1'b0;
      if (idle_ok && we && !wsel && int'(waddr) < XLEN) xtab[waddr[2:0]] <= wdata[XW-1:0];
      if (idle_ok && we && wsel && int'(waddr) < DLEN) dtab[waddr] <= wdata;
      if (go) begin
        state <= S_RUN;
        phase <= '0;
        i <= '0;
        j <= '0;
        pass <= '0;
        done <= 1'b0;
      end else if (busy) begin
        phase <= (int'(phase) == FRAME - 1) ? '0 : phase + 1'b1;
        if (phase == '0) begin
          xn <= xtab[i];
          d <= dtab[j];
          stb <= 1'b1;
        end
        if (fend) begin
          i <= i + 1'b1;
          j <= (j == 4'd8) ? 4'd1 : j + 1'b1;
          if (i == 3'd7) pass <= pass + 1'b1;
          if (last) begin
            state <= S_DONE;
            done <= 1'b1;
          end
        end
      end
    end
  end
  fxb_errmon #(.DW(DW), .THR(THR), .CONV(CONV)) u_errmon (
    .clk(clk),
    .r(r),
    .clr(go),
    .en(fend),
    .e_in(e_in),
    .conv(conv)
  );
endmodule

// File: tb/tb_fxb_source.sv
// tb_fxb_source: randomized scoreboard bench for fxb_source against a table/window reference model
module tb_fxb_source;
  localparam int XW = 8, DW = 10, FRAME = 8, NPASS = 4, THR = 4, CONV = 16, NS = 8 * NPASS;
  logic clk = 1'b0, r = 1'b0, start = 1'b0, we = 1'b0, wsel = 1'b0;
  logic [3:0] waddr = '0;
  logic [DW-1:0] wdata = '0, e_in = '0;
  logic [XW-1:0] xn;
  logic [DW-1:0] d;
  logic stb, busy, done, conv;
  logic [5:0] pass;
  typedef struct {int x; int d; bit c; int gap;} exp_t;
  exp_t exp_q[$];
  int e_q[$];
  int mx[8], md[9], errs[NS];
  int checks = 0, errors = 0, gap_cnt = 0;
  fxb_source #(.XW(XW), .DW(DW), .FRAME(FRAME), .NPASS(NPASS), .THR(THR), .CONV(CONV)) dut (
    .clk(clk), .r(r), .start(start), .we(we), .wsel(wsel), .waddr(waddr), .wdata(wdata),
    .e_in(e_in), .xn(xn), .d(d), .stb(stb), .busy(busy), .done(done), .conv(conv), .pass(pass)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction
  function automatic bit win_ok(input int k);
    if (k < CONV) return 1'b0;
    for (int m = k - CONV; m < k; m++) if (iabs(errs[m]) > THR) return 1'b0;
    return 1'b1;
  endfunction
  task automatic mwrite(input bit s, input int a, input int v);
    if (!s && a < 8) mx[a] = v & 255;
    if (s && a < 9) md[a] = v & 1023;
  endtask
  task automatic wr(input bit s, input int a, input int v, input bit apply);
    @(negedge clk);
    we = 1'b1;
    wsel = s;
    waddr = 4'(a);
    wdata = DW'(v);
    @(negedge clk);
    we = 1'b0;
    if (apply) mwrite(s, a, v);
  endtask
  task automatic load_random();
    for (int k = 0; k < 8; k++) wr(1'b0, k, int'($urandom_range(0, 1023)), 1'b1);
    for (int k = 0; k < 9; k++) wr(1'b1, k, int'($urandom_range(0, 1023)), 1'b1);
  endtask
  task automatic launch(input bit w, input int a, input int v);
    if (w) mwrite(1'b1, a, v);
    for (int k = 0; k < NS; k++) begin
      exp_t e;
      e.x = mx[k % 8];
      e.d = md[(k == 0) ? 0 : ((k - 1) % 8) + 1];
      e.c = win_ok(k);
      e.gap = (k == 0) ? 1 : FRAME;
      exp_q.push_back(e);
      e_q.push_back(errs[k]);
    end
    @(negedge clk);
    start = 1'b1;
    we = w;
    wsel = 1'b1;
    waddr = 4'(a);
    wdata = DW'(v);
    @(negedge clk);
    start = 1'b0;
    we = 1'b0;
  endtask
  task automatic finish_run();
    int n = 0;
    while (!done && n < NS * FRAME + 16) begin
      @(negedge clk);
      n++;
    end
    chk("done", int'(done), 1);
    chk("pass_end", int'(pass), NPASS);
    chk("busy_end", int'(busy), 0);
    chk("conv_end", int'(conv), int'(win_ok(NS)));
    chk("samples_left", exp_q.size(), 0);
  endtask
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      gap_cnt++;
      if (start && r) gap_cnt = 0;
      if (r && stb) begin
        if (exp_q.size() == 0) chk("stb_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("xn", int'(xn), e.x);
          chk("d", int'(d), e.d);
          chk("conv", int'(conv), int'(e.c));
          chk("stb_gap", gap_cnt, e.gap);
          chk("busy", int'(busy), 1);
          chk("done_in_run", int'(done), 0);
        end
        gap_cnt = 0;
      end
    end
  end
  initial begin : edrv
    forever begin
      @(posedge clk);
      #1;
      if (r && stb) e_in = DW'((e_q.size() > 0) ? e_q.pop_front() : 0);
    end
  end
  initial begin : stim
    int n;
    repeat (2) @(negedge clk);
    chk("rst_xn", int'(xn), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_stb", int'(stb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_conv", int'(conv), 0);
    chk("rst_pass", int'(pass), 0);
    r = 1'b1;
    for (int k = 0; k < 8; k++) mx[k] = 0;
    for (int k = 0; k < 9; k++) md[k] = 0;
    for (int k = 0; k < NS; k++) errs[k] = -512;
    launch(1'b0, 0, 0);
    finish_run();
    begin
      int xv[8] = '{16, 32, 48, 32, 16, 0, 0, 0};
      int dv[9] = '{0, 8, 20, 34, 33, 24, 11, 4, 1};
      for (int k = 0; k < 8; k++) wr(1'b0, k, xv[k], 1'b1);
      for (int k = 0; k < 9; k++) wr(1'b1, k, dv[k], 1'b1);
    end
    wr(1'b1, 9, 1023, 1'b1);
    wr(1'b0, 12, 1023, 1'b1);
    for (int k = 0; k < NS; k++) errs[k] = (k < 15) ? 3 : (k == 15) ? -5 : (k < 32) ? -4 : 0;
    launch(1'b0, 0, 0);
    repeat (40) @(negedge clk);
    wr(1'b0, 2, 1023, 1'b0);
    wr(1'b1, 3, 1023, 1'b0);
    finish_run();
    load_random();
    for (int k = 0; k < NS; k++) errs[k] = ($urandom_range(0, 24) == 0) ? 5 : int'($urandom_range(0, 8)) - 4;
    launch(1'b1, 0, int'($urandom_range(0, 1023)));
    finish_run();
    load_random();
    for (int k = 0; k < NS; k++) errs[k] = int'($urandom_range(0, 8)) - 4;
    launch(1'b0, 0, 0);
    n = 0;
    while (exp_q.size() > NS - 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_samples", exp_q.size(), NS - 5);
    r = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_xn", int'(xn), 0);
    chk("mid_d", int'(d), 0);
    chk("mid_stb", int'(stb), 0);
    chk("mid_pass", int'(pass), 0);
    exp_q.delete();
    e_q.delete();
    for (int k = 0; k < 8; k++) mx[k] = 0;
    for (int k = 0; k < 9; k++) md[k] = 0;
    @(negedge clk);
    r = 1'b1;
    load_random();
    launch(1'b0, 0, 0);
    finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
